goruntu_okuyucu: RTL and testbench

- Frame-reader / pixel-stream transmitter that feeds the task unit's pixel input.
- On a start command, reads a GENISLIK x YUKSEKLIK 8-bit grayscale frame from a synchronous BRAM read port (1-cycle latency) in raster order.
- Drives the valid/pixel/stall stream into gorev_birimi and issues its basla pulse and task code beforehand.
- Owns the source end of the protocol: a transfer occurs only on a cycle with etkin_o=1 and stal_i=0.

---
 rtl/goruntu_okuyucu_pkg.sv | 7 +
 rtl/goruntu_okuyucu_tampon.sv | 34 +++
 rtl/goruntu_okuyucu.sv | 110 +++++++++++
 tb/tb_goruntu_okuyucu.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/goruntu_okuyucu_pkg.sv
// goruntu_okuyucu_pkg: task codes, FSM state encoding and read latency shared by the frame reader
package goruntu_okuyucu_pkg;
  localparam logic [2:0] GRV4_H  = 3'd4;
  localparam logic [2:0] GRV5_HE = 3'd5;
  localparam int OKU_GECIKME = 1;
  typedef enum logic [2:0] {BOS, BASLAT, AKIS, BOSALT, BITTI} durum_t;
endpackage

// File: rtl/goruntu_okuyucu_tampon.sv
// okuyucu_tampon: 2-entry skid FIFO with a registered head so pixel_o comes straight from a flop
module okuyucu_tampon (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] veri_i,
  input  logic       pop_i,
  output logic [7:0] bas_o,
  output logic [1:0] doluluk_o
);
  logic [7:0] r_bas;
  logic [7:0] r_ikinci;
  logic [1:0] r_dol;
  assign bas_o = r_bas;
  assign doluluk_o = r_dol;
  // head refills from the second slot on a pop, or from the incoming word when it would be next in line
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bas <= '0;
      r_ikinci <= '0;
      r_dol <= '0;
    end else begin
      r_dol <= r_dol + 2'(push_i) - 2'(pop_i);
      if (pop_i && r_dol == 2'd2)
        r_bas <= r_ikinci;
      else if (push_i && (r_dol == 2'd0 || (pop_i && r_dol == 2'd1)))
        r_bas <= veri_i;
      if (push_i && (r_dol == 2'd2 || (r_dol == 2'd1 && !pop_i)))
        r_ikinci <= veri_i;
    end
  end
  a_tasma: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && !pop_i && r_dol == 2'd2));
  a_bos_pop: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && r_dol == 2'd0));
endmodule

// File: rtl/goruntu_okuyucu.sv
// goruntu_okuyucu: streams a BRAM frame in raster order to gorev_birimi; GORUNTU_OKUYUCU_CIFT_GECIS_EN adds a GRV4_H pre-pass for GRV5_HE
module goruntu_okuyucu
  import goruntu_okuyucu_pkg::*;
#(
  parameter int GENISLIK  = 320,
  parameter int YUKSEKLIK = 240,
  parameter int ADR_W     = 17
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             basla_i,
  input  logic [2:0]       gorev_i,
  output logic             mesgul_o,
  output logic             bitti_o,
  output logic [2:0]       gorev_o,
  output logic             basla_o,
  output logic             mem_oku_o,
  output logic [ADR_W-1:0] mem_adres_o,
  input  logic [7:0]       mem_veri_i,
  output logic             etkin_o,
  output logic [7:0]       pixel_o,
  input  logic             stal_i
);
  localparam int PIKSEL = GENISLIK * YUKSEKLIK;
  localparam int SAY_W = $clog2(PIKSEL + 1);
  localparam int DERINLIK = OKU_GECIKME + 1;
  localparam logic [ADR_W-1:0] SON_ADRES = ADR_W'(PIKSEL - 1);
  localparam logic [SAY_W-1:0] SON_AKTARIM = SAY_W'(PIKSEL - 1);
  durum_t r_durum;
  durum_t w_sonraki;
  logic [2:0] r_gorev;
  logic r_cift;
  logic r_bekleyen;
  logic [ADR_W-1:0] r_adres;
  logic [SAY_W-1:0] r_aktarim;
  logic [1:0] w_doluluk;
  logic [2:0] w_istek;
  logic w_okuma_evresi;
  logic w_oku;
  logic w_pop;
  logic w_son;
  logic w_cift;
`ifdef GORUNTU_OKUYUCU_CIFT_GECIS_EN
  assign w_cift = gorev_i == GRV5_HE;
`else
  assign w_cift = 1'b0;
`endif
  assign etkin_o = |w_doluluk;
  assign w_pop = etkin_o & ~stal_i;
  assign w_son = w_pop && r_aktarim == SON_AKTARIM;
  assign w_istek = {1'b0, w_doluluk} + {2'b0, r_bekleyen} - {2'b0, w_pop};
  assign w_okuma_evresi = r_durum == BASLAT || r_durum == AKIS;
  assign w_oku = w_okuma_evresi && w_istek < 3'(DERINLIK);
  okuyucu_tampon u_tampon (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (r_bekleyen),
    .veri_i    (mem_veri_i),
    .pop_i     (w_pop),
    .bas_o     (pixel_o),
    .doluluk_o (w_doluluk)
  );
  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_durum <= BOS;
    else r_durum <= w_sonraki;
  end
  // next state: the frame ends on the last transfer, which also guarantees an empty FIFO and no read in flight
  always_comb begin
    w_sonraki = r_durum;
    case (r_durum)
      BOS:     w_sonraki = basla_i ? BASLAT : BOS;
      BASLAT:  w_sonraki = AKIS;
      AKIS:    w_sonraki = (w_oku && r_adres == SON_ADRES) ? BOSALT : AKIS;
      BOSALT:  w_sonraki = w_son ? (r_cift ? BASLAT : BITTI) : BOSALT;
      BITTI:   w_sonraki = BOS;
      default: w_sonraki = BOS;
    endcase
  end
  // outputs decoded from state; the first read is issued in BASLAT so pixels start two cycles after basla_o
  always_comb begin
    basla_o = r_durum == BASLAT;
    bitti_o = r_durum == BITTI;
    mesgul_o = r_durum != BOS && r_durum != BITTI;
    mem_oku_o = w_oku;
    mem_adres_o = r_adres;
    gorev_o = r_gorev;
  end
  // read address, in-flight flag, per-pass transfer count and task capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bekleyen <= 1'b0;
      r_adres <= '0;
      r_aktarim <= '0;
      r_gorev <= '0;
      r_cift <= 1'b0;
    end else begin
      r_bekleyen <= w_oku;
      r_adres <= w_okuma_evresi ? r_adres + ADR_W'(w_oku) : '0;
      r_aktarim <= r_durum == BASLAT ? '0 : r_aktarim + SAY_W'(w_pop);
      if (r_durum == BOS && basla_i) begin
        r_gorev <= w_cift ? GRV4_H : gorev_i;
        r_cift <= w_cift;
      end else if (r_durum == BOSALT && w_son && r_cift) begin
        r_gorev <= GRV5_HE;
        r_cift <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_goruntu_okuyucu.sv
// tb_goruntu_okuyucu: directed frames on a 4x2 image with free-running, alternating and long stalls, mid-frame start, reset abort and GRV5_HE
module tb_goruntu_okuyucu;
  import goruntu_okuyucu_pkg::*;
  localparam int N = 8;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic basla_i = 1'b0;
  logic [2:0] gorev_i = 3'd0;
  logic stal_i = 1'b0;
  logic [7:0] mem_veri_i = 8'd0;
  logic mesgul_o, bitti_o, basla_o, mem_oku_o, etkin_o;
  logic [2:0] gorev_o;
  logic [2:0] mem_adres_o;
  logic [7:0] pixel_o;
  logic [7:0] bram [N] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};

  goruntu_okuyucu #(.GENISLIK(4), .YUKSEKLIK(2), .ADR_W(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .basla_i(basla_i), .gorev_i(gorev_i),
    .mesgul_o(mesgul_o), .bitti_o(bitti_o), .gorev_o(gorev_o), .basla_o(basla_o),
    .mem_oku_o(mem_oku_o), .mem_adres_o(mem_adres_o), .mem_veri_i(mem_veri_i),
    .etkin_o(etkin_o), .pixel_o(pixel_o), .stal_i(stal_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) if (mem_oku_o) mem_veri_i <= bram[mem_adres_o];

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int kontrol_say = 0, hata_say = 0;
  task automatic kontrol(input string tag, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    kontrol_say++;
    if (gozlenen !== beklenen) begin
      hata_say++;
      $display("FAIL %s gozlenen=%0h beklenen=%0h", tag, gozlenen, beklenen);
    end
  endtask

  int n_tr, n_basla, n_bitti, ilk_etkin, son_tr, ilk_basla, bitti_cyc, yolda, yolda_max, n_kayma, pencere_oku;
  logic bitti_mesgul;
  logic [7:0] pencere_pix;
  logic [7:0] pix [$];
  logic [2:0] gorevler [$];
  logic onceki_stal = 1'b0;
  logic [7:0] onceki_pix = 8'd0;
  int mod = 0, kalan = 0;
  logic pencere_basladi = 1'b0;

  always @(negedge clk_i) if (!rst_i) begin
    if (onceki_stal && (!etkin_o || pixel_o !== onceki_pix)) n_kayma++;
    onceki_stal = etkin_o && stal_i;
    onceki_pix = pixel_o;
    if (basla_o) begin
      if (n_basla == 0) ilk_basla = cyc;
      n_basla++;
      gorevler.push_back(gorev_o);
    end
    if (etkin_o && !stal_i) begin
      pix.push_back(pixel_o);
      if (n_tr == 0) ilk_etkin = cyc;
      son_tr = cyc;
      n_tr++;
    end
    if (bitti_o) begin
      n_bitti++;
      bitti_cyc = cyc;
      bitti_mesgul = mesgul_o;
    end
    yolda += int'(mem_oku_o) - int'(etkin_o && !stal_i);
    if (yolda > yolda_max) yolda_max = yolda;
    if (kalan == 10) pencere_pix = pixel_o;
    if (kalan > 0 && mem_oku_o) pencere_oku++;
  end

  always @(posedge clk_i) begin
    #1;
    if (mod == 2 && !pencere_basladi && n_tr == 3) begin
      pencere_basladi = 1'b1;
      kalan = 10;
    end else if (kalan > 0) kalan--;
    stal_i = mod == 1 ? cyc[0] : kalan > 0;
  end

  task automatic baslat(input logic [2:0] g, output int bas);
    n_tr = 0; n_basla = 0; n_bitti = 0; ilk_etkin = 0; son_tr = 0; ilk_basla = 0; bitti_cyc = 0;
    yolda = 0; yolda_max = 0; n_kayma = 0; pencere_oku = 0; bitti_mesgul = 1'b0; pencere_pix = 8'd0;
    pix.delete(); gorevler.delete();
    @(posedge clk_i); #1;
    basla_i = 1'b1; gorev_i = g; bas = cyc;
    @(posedge clk_i); #1;
    basla_i = 1'b0;
  endtask

  task automatic kare(input string ad, input logic [2:0] g, input int ek);
    int bas, gecis, hatalar;
    baslat(g, bas);
    gecis = 1;
`ifdef GORUNTU_OKUYUCU_CIFT_GECIS_EN
    if (g == GRV5_HE) gecis = 2;
`endif
    if (ek == 1) begin
      for (int i = 0; i < 200 && n_tr < 3; i++) begin @(posedge clk_i); #1; end
      basla_i = 1'b1; gorev_i = 3'd6;
      @(posedge clk_i); #1;
      basla_i = 1'b0;
    end
    if (ek == 2) begin
      while (cyc != bas + 11) begin @(posedge clk_i); #1; end
      basla_i = 1'b1;
      @(posedge clk_i); #1;
      basla_i = 1'b0;
    end
    for (int i = 0; i < 400 && n_bitti == 0; i++) @(posedge clk_i);
    repeat (4) @(posedge clk_i);
    #1;
    kontrol({ad, "_bitti_sayisi"}, n_bitti, 1);
    kontrol({ad, "_aktarim"}, n_tr, N * gecis);
    kontrol({ad, "_basla_sayisi"}, n_basla, gecis);
    kontrol({ad, "_basla_gecikme"}, ilk_basla - bas, 1);
    kontrol({ad, "_ilk_etkin"}, ilk_etkin - ilk_basla, 2);
    kontrol({ad, "_bitti_gecikme"}, bitti_cyc - son_tr, 1);
    kontrol({ad, "_bitti_mesgul"}, bitti_mesgul, 0);
    kontrol({ad, "_kayma"}, n_kayma, 0);
    kontrol({ad, "_tasma"}, yolda_max > 2, 0);
    kontrol({ad, "_mesgul_son"}, mesgul_o, 0);
    hatalar = 0;
    foreach (pix[i]) if (pix[i] !== 8'(8'h10 + i % N)) hatalar++;
    kontrol({ad, "_sira"}, hatalar, 0);
    if (gecis == 2) begin
      kontrol({ad, "_gorev1"}, gorevler[0], GRV4_H);
      kontrol({ad, "_gorev2"}, gorevler[1], GRV5_HE);
    end else kontrol({ad, "_gorev"}, gorevler[0], g);
    if (mod == 0 && gecis == 1) kontrol({ad, "_ardisik"}, son_tr - ilk_etkin, N - 1);
  endtask

  initial begin
    int bas;
    repeat (3) @(posedge clk_i);
    #1;
    kontrol("reset_cikis", {mesgul_o, bitti_o, gorev_o, basla_o, mem_oku_o, mem_adres_o, etkin_o, pixel_o}, 0);
    rst_i = 1'b0;
    mod = 0;
    kare("akis", 3'd1, 0);
    mod = 1;
    kare("tek_stal", 3'd2, 0);
    mod = 2;
    pencere_basladi = 1'b0;
    kare("uzun_stal", 3'd3, 0);
    kontrol("uzun_stal_bas", pencere_pix, 8'h13);
    kontrol("uzun_stal_okuma", pencere_oku, 0);
    mod = 0;
    kare("ara_basla", 3'd1, 1);
    kare("bitti_basla", 3'd0, 2);
    baslat(3'd2, bas);
    for (int i = 0; i < 200 && n_tr < 5; i++) @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    kontrol("abort_cikis", {mesgul_o, bitti_o, gorev_o, basla_o, mem_oku_o, mem_adres_o, etkin_o, pixel_o}, 0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #1;
    kontrol("abort_bitti", n_bitti, 0);
    kontrol("abort_mesgul", mesgul_o, 0);
    kare("yeniden", 3'd1, 0);
    kare("cift", GRV5_HE, 0);
    $display("TB_RESULT checks=%0d failures=%0d", kontrol_say, hata_say);
    $finish;
  end
endmodule
